cell_stream_deser: RTL and testbench

//  Parametrised stream-to-flat-packet deserialiser for bench and sim top levels. Collects one

---
 rtl/cell_stream_deser.sv | 124 ++++++++++++
 tb/tb_cell_stream_deser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_stream_deser.sv
// Stream-to-flat-packet deserialiser: gathers one tlast-delimited packet of up to NWORDS
// words into a flat register, with optional valid/ready hold and malformed-packet handling.
module cell_stream_deser #(
  parameter            NAME        = "",
  parameter int        DW          = 32,
  parameter int        NWORDS      = 4,
  parameter bit        STROBE_MODE = 1'b1,
  parameter bit        STRICT      = 1'b0,
  localparam int       LW          = $clog2(NWORDS + 1) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tvalid,
  input  logic                 tlast,
  input  logic [DW-1:0]        tdata,
  output logic                 tready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NWORDS*DW-1:0] out_data,
  output logic [LW-1:0]        out_len,
  output logic                 out_err,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          err_cnt
);

  localparam logic [LW-1:0] NW_L  = LW'(NWORDS);
  localparam logic [LW-1:0] SAT_L = LW'(NWORDS + 1);

  logic [NWORDS*DW-1:0] buf_r;
  logic [LW-1:0]        cnt_r;

  logic                 tready_s;
  logic                 beat_s;
  logic [LW-1:0]        len_s;
  logic                 short_s;
  logic                 long_s;
  logic                 bad_s;
  logic                 pub_s;
  logic                 pop_s;
  logic [NWORDS*DW-1:0] merged_s;

  // Input acceptance: only stall the stream while an unconsumed packet is held.
  always_comb begin
    tready_s = 1'b1;
    if (STROBE_MODE) begin
      tready_s = 1'b1;
    end else begin
      tready_s = !out_valid || out_ready;
    end
  end

  assign tready = tready_s;

  // Beat decode, saturating length and the buffer with the current beat merged in.
  always_comb begin
    beat_s = tvalid && tready_s;
    if (cnt_r == SAT_L) begin
      len_s = SAT_L;
    end else begin
      len_s = cnt_r + LW'(1);
    end
    short_s = (len_s < NW_L);
    long_s  = (len_s > NW_L);
    bad_s   = short_s || long_s;
    pub_s   = beat_s && tlast && ((STRICT == 1'b0) || !bad_s);
    pop_s   = out_valid && out_ready;
    merged_s = buf_r;
    // Beats past the last slot never match an index and are dropped here.
    for (int k = 0; k < NWORDS; k++) begin
      if (cnt_r == LW'(k)) begin
        merged_s[k*DW +: DW] = tdata;
      end else begin
        merged_s[k*DW +: DW] = buf_r[k*DW +: DW];
      end
    end
  end

  // Packet assembly, publish registers and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_r     <= '0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      out_err   <= 1'b0;
      pkt_cnt   <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      if (beat_s) begin
        if (tlast) begin
          buf_r <= '0;
          cnt_r <= '0;
          if (bad_s && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end else begin
          buf_r <= merged_s;
          if (cnt_r != SAT_L) begin
            cnt_r <= cnt_r + LW'(1);
          end
        end
      end

      if (pub_s) begin
        out_data <= merged_s;
        out_len  <= len_s;
        out_err  <= bad_s;
        pkt_cnt  <= pkt_cnt + 16'd1;
      end

      if (STROBE_MODE) begin
        out_valid <= pub_s;
      end else if (pub_s) begin
        out_valid <= 1'b1;
      end else if (pop_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_cell_stream_deser.sv
// Directed bench for cell_stream_deser: strobe/lenient, strobe/strict, hold-mode and a
// hold-mode NWORDS=8 instance fed random good packets against a scoreboard.
module tb_cell_stream_deser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instances A (STRICT=0) and B (STRICT=1) share one strobe-mode stream.
  logic        ab_tvalid, ab_tlast, ab_out_ready;
  logic [31:0] ab_tdata;
  logic        a_tready, a_out_valid, a_out_err;
  logic [127:0] a_out_data;
  logic [3:0]  a_out_len;
  logic [15:0] a_pkt_cnt, a_err_cnt;
  logic        b_tready, b_out_valid, b_out_err;
  logic [127:0] b_out_data;
  logic [3:0]  b_out_len;
  logic [15:0] b_pkt_cnt, b_err_cnt;

  logic        c_tvalid, c_tlast, c_out_ready;
  logic [31:0] c_tdata;
  logic        c_tready, c_out_valid, c_out_err;
  logic [127:0] c_out_data;
  logic [3:0]  c_out_len;
  logic [15:0] c_pkt_cnt, c_err_cnt;

  logic        d_tvalid, d_tlast, d_out_ready;
  logic [15:0] d_tdata;
  logic        d_tready, d_out_valid, d_out_err;
  logic [127:0] d_out_data;
  logic [4:0]  d_out_len;
  logic [15:0] d_pkt_cnt, d_err_cnt;

  cell_stream_deser #(.NAME("A"), .DW(32), .NWORDS(4), .STROBE_MODE(1'b1), .STRICT(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .tvalid(ab_tvalid), .tlast(ab_tlast), .tdata(ab_tdata),
    .tready(a_tready), .out_valid(a_out_valid), .out_ready(ab_out_ready), .out_data(a_out_data),
    .out_len(a_out_len), .out_err(a_out_err), .pkt_cnt(a_pkt_cnt), .err_cnt(a_err_cnt));

  cell_stream_deser #(.NAME("B"), .DW(32), .NWORDS(4), .STROBE_MODE(1'b1), .STRICT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .tvalid(ab_tvalid), .tlast(ab_tlast), .tdata(ab_tdata),
    .tready(b_tready), .out_valid(b_out_valid), .out_ready(ab_out_ready), .out_data(b_out_data),
    .out_len(b_out_len), .out_err(b_out_err), .pkt_cnt(b_pkt_cnt), .err_cnt(b_err_cnt));

  cell_stream_deser #(.NAME("C"), .DW(32), .NWORDS(4), .STROBE_MODE(1'b0), .STRICT(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .tvalid(c_tvalid), .tlast(c_tlast), .tdata(c_tdata),
    .tready(c_tready), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_len(c_out_len), .out_err(c_out_err), .pkt_cnt(c_pkt_cnt), .err_cnt(c_err_cnt));

  cell_stream_deser #(.NAME("D"), .DW(16), .NWORDS(8), .STROBE_MODE(1'b0), .STRICT(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .tvalid(d_tvalid), .tlast(d_tlast), .tdata(d_tdata),
    .tready(d_tready), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_len(d_out_len), .out_err(d_out_err), .pkt_cnt(d_pkt_cnt), .err_cnt(d_err_cnt));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ab_beat(input logic [31:0] d, input logic l);
    ab_tvalid = 1'b1;
    ab_tdata  = d;
    ab_tlast  = l;
    tick();
    ab_tvalid = 1'b0;
    ab_tlast  = 1'b0;
  endtask

  task automatic c_beat(input logic [31:0] d, input logic l);
    c_tvalid = 1'b1;
    c_tdata  = d;
    c_tlast  = l;
    tick();
    c_tvalid = 1'b0;
    c_tlast  = 1'b0;
  endtask

  logic [127:0] cur, mdl_data, c_hold;
  logic         mdl_valid, exp_tready, pop, acc;
  int           pk, wd, cyc;

  initial begin
    ab_tvalid = 1'b0; ab_tlast = 1'b0; ab_tdata = 32'h0; ab_out_ready = 1'b0;
    c_tvalid = 1'b0; c_tlast = 1'b0; c_tdata = 32'h0; c_out_ready = 1'b0;
    d_tvalid = 1'b0; d_tlast = 1'b0; d_tdata = 16'h0; d_out_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();

    chk("rst_a_valid", a_out_valid, 1'b0);
    chk("rst_a_data", a_out_data, 128'h0);
    chk("rst_a_len", a_out_len, 4'd0);
    chk("rst_a_pkt", a_pkt_cnt, 16'd0);
    chk("rst_c_tready", c_tready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Good 4-word packet
    ab_beat(32'h11, 1'b0); ab_beat(32'h22, 1'b0); ab_beat(32'h33, 1'b0); ab_beat(32'h44, 1'b1);
    chk("t1_valid", a_out_valid, 1'b1);
    chk("t1_data", a_out_data, 128'h00000044_00000033_00000022_00000011);
    chk("t1_len", a_out_len, 4'd4);
    chk("t1_err", a_out_err, 1'b0);
    chk("t1_pkt", a_pkt_cnt, 16'd1);
    chk("t1_b_valid", b_out_valid, 1'b1);
    tick();
    chk("t1_strobe_low", a_out_valid, 1'b0);
    chk("t1_data_hold", a_out_data, 128'h00000044_00000033_00000022_00000011);

    // Short packet
    ab_beat(32'hA, 1'b0); ab_beat(32'hB, 1'b1);
    chk("t2_valid", a_out_valid, 1'b1);
    chk("t2_data", a_out_data, 128'h00000000_00000000_0000000B_0000000A);
    chk("t2_len", a_out_len, 4'd2);
    chk("t2_err", a_out_err, 1'b1);
    chk("t2_errcnt", a_err_cnt, 16'd1);
    chk("t2_pkt", a_pkt_cnt, 16'd2);
    chk("t2_b_valid", b_out_valid, 1'b0);
    chk("t2_b_pkt", b_pkt_cnt, 16'd1);
    chk("t2_b_errcnt", b_err_cnt, 16'd1);

    // Long packet, then a good one
    for (int i = 1; i <= 6; i++) ab_beat(32'(i), (i == 6));
    chk("t3_valid", a_out_valid, 1'b1);
    chk("t3_data", a_out_data, 128'h00000004_00000003_00000002_00000001);
    chk("t3_len", a_out_len, 4'd5);
    chk("t3_err", a_out_err, 1'b1);
    chk("t3_errcnt", a_err_cnt, 16'd2);
    chk("t3_b_valid", b_out_valid, 1'b0);
    chk("t3_b_errcnt", b_err_cnt, 16'd2);
    ab_beat(32'h55, 1'b0); ab_beat(32'h66, 1'b0); ab_beat(32'h77, 1'b0); ab_beat(32'h88, 1'b1);
    chk("t3g_err", a_out_err, 1'b0);
    chk("t3g_len", a_out_len, 4'd4);
    chk("t3g_pkt", a_pkt_cnt, 16'd4);
    chk("t3g_b_valid", b_out_valid, 1'b1);
    chk("t3g_b_pkt", b_pkt_cnt, 16'd2);
    chk("t3g_b_data", b_out_data, 128'h00000088_00000077_00000066_00000055);

    // Back-to-back single-beat packets
    ab_beat(32'hE1, 1'b1);
    chk("bb1_valid", a_out_valid, 1'b1);
    chk("bb1_data", a_out_data, 128'hE1);
    chk("bb1_len", a_out_len, 4'd1);
    chk("bb1_err", a_out_err, 1'b1);
    chk("bb1_pkt", a_pkt_cnt, 16'd5);
    ab_beat(32'hE2, 1'b1);
    chk("bb2_valid", a_out_valid, 1'b1);
    chk("bb2_data", a_out_data, 128'hE2);
    chk("bb2_pkt", a_pkt_cnt, 16'd6);
    chk("bb2_errcnt", a_err_cnt, 16'd4);
    chk("bb2_b_errcnt", b_err_cnt, 16'd4);
    tick();
    chk("bb_end_valid", a_out_valid, 1'b0);

    // Hold mode back-pressure
    c_beat(32'hC1, 1'b0); c_beat(32'hC2, 1'b0); c_beat(32'hC3, 1'b0); c_beat(32'hC4, 1'b1);
    c_hold = 128'h000000C4_000000C3_000000C2_000000C1;
    chk("t4_valid", c_out_valid, 1'b1);
    chk("t4_data", c_out_data, c_hold);
    chk("t4_tready", c_tready, 1'b0);
    c_tvalid = 1'b1; c_tdata = 32'hD1; c_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_tready", c_tready, 1'b0);
      chk("t4_stall_valid", c_out_valid, 1'b1);
      chk("t4_stall_data", c_out_data, c_hold);
    end
    c_out_ready = 1'b1;
    #1;
    chk("t4_ready_tready", c_tready, 1'b1);
    tick();
    c_tvalid = 1'b0;
    c_out_ready = 1'b0;
    chk("t4_popped", c_out_valid, 1'b0);
    c_beat(32'hD2, 1'b0); c_beat(32'hD3, 1'b0); c_beat(32'hD4, 1'b1);
    chk("t4n_valid", c_out_valid, 1'b1);
    chk("t4n_data", c_out_data, 128'h000000D4_000000D3_000000D2_000000D1);
    chk("t4n_len", c_out_len, 4'd4);
    chk("t4n_pkt", c_pkt_cnt, 16'd2);

    // Reset in the middle of a packet
    ab_beat(32'h1, 1'b0); ab_beat(32'h2, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_valid", a_out_valid, 1'b0);
    chk("t5_rst_pkt", a_pkt_cnt, 16'd0);
    chk("t5_rst_errcnt", a_err_cnt, 16'd0);
    chk("t5_rst_data", a_out_data, 128'h0);
    chk("t5_rst_b_pkt", b_pkt_cnt, 16'd0);
    chk("t5_rst_c_valid", c_out_valid, 1'b0);
    rst_n = 1'b1;
    ab_beat(32'hA1, 1'b0); ab_beat(32'hA2, 1'b0); ab_beat(32'hA3, 1'b0); ab_beat(32'hA4, 1'b1);
    chk("t5_valid", a_out_valid, 1'b1);
    chk("t5_data", a_out_data, 128'h000000A4_000000A3_000000A2_000000A1);
    chk("t5_len", a_out_len, 4'd4);
    chk("t5_err", a_out_err, 1'b0);
    chk("t5_pkt", a_pkt_cnt, 16'd1);
    chk("t5_errcnt", a_err_cnt, 16'd0);

    // Random good packets through the NWORDS=8 hold-mode instance
    pk = 0; wd = 0; cyc = 0; mdl_valid = 1'b0; mdl_data = 128'h0;
    for (int k = 0; k < 8; k++) cur[k*16 +: 16] = 16'($urandom);
    while (((pk < 100) || mdl_valid) && (cyc < 20000)) begin
      d_tvalid    = (pk < 100) && ($urandom_range(0, 3) != 0);
      d_tdata     = cur[wd*16 +: 16];
      d_tlast     = (wd == 7);
      d_out_ready = ($urandom_range(0, 2) != 0);
      exp_tready  = !mdl_valid || d_out_ready;
      #1;
      chk("t6_tready", d_tready, exp_tready);
      chk("t6_valid", d_out_valid, mdl_valid);
      if (mdl_valid) chk("t6_data", d_out_data, mdl_data);
      tick();
      pop = mdl_valid && d_out_ready;
      acc = d_tvalid && exp_tready;
      if (acc && (wd == 7)) begin
        mdl_valid = 1'b1;
        mdl_data  = cur;
        pk++;
        wd = 0;
        for (int k = 0; k < 8; k++) cur[k*16 +: 16] = 16'($urandom);
      end else begin
        if (acc) wd++;
        if (pop) mdl_valid = 1'b0;
      end
      cyc++;
    end
    d_tvalid = 1'b0;
    d_out_ready = 1'b0;
    chk("t6_no_timeout", (cyc < 20000), 1'b1);
    chk("t6_pkt", d_pkt_cnt, 16'd100);
    chk("t6_errcnt", d_err_cnt, 16'd0);
    chk("t6_len", d_out_len, 5'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
